// File: rtl/simple_bus_arbiter.sv
// Two-requester round-robin arbiter for a single shared bus.
// Issues one command per arbitration and returns read data after RD_LATENCY cycles.
module simple_bus_arbiter #(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_op,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wr_data,
    input  logic        m1_req,
    input  logic        m1_op,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wr_data,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rd_valid,
    output logic        m1_rd_valid,
    output logic [15:0] m0_rd_data,
    output logic [15:0] m1_rd_data,
    output logic        bus_valid,
    output logic        bus_op,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wr_data,
    input  logic [15:0] bus_rd_data,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    localparam logic [3:0] LAT = 4'(RD_LATENCY);

    state_t      state, state_nxt;
    logic        last, last_nxt;     // 1 = m1 was granted last
    logic        sel, sel_nxt;       // owner of the transaction in flight
    logic [3:0]  cnt, cnt_nxt;
    logic        pick;
    logic        m0_gnt_nxt, m1_gnt_nxt;
    logic        m0_rd_valid_nxt, m1_rd_valid_nxt;
    logic [15:0] m0_rd_data_nxt, m1_rd_data_nxt;
    logic        bus_valid_nxt, bus_op_nxt;
    logic [15:0] bus_addr_nxt, bus_wr_data_nxt;

    always_comb begin
        state_nxt       = state;
        last_nxt        = last;
        sel_nxt         = sel;
        cnt_nxt         = cnt;
        pick            = 1'b0;
        m0_gnt_nxt      = 1'b0;
        m1_gnt_nxt      = 1'b0;
        m0_rd_valid_nxt = 1'b0;
        m1_rd_valid_nxt = 1'b0;
        m0_rd_data_nxt  = m0_rd_data;
        m1_rd_data_nxt  = m1_rd_data;
        bus_valid_nxt   = 1'b0;
        bus_op_nxt      = 1'b0;
        bus_addr_nxt    = '0;
        bus_wr_data_nxt = '0;

        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // On conflict the requester not granted last wins.
                    pick          = (m0_req && m1_req) ? ~last : m1_req;
                    sel_nxt       = pick;
                    last_nxt      = pick;
                    state_nxt     = ISSUE;
                    bus_valid_nxt = 1'b1;
                    m0_gnt_nxt    = ~pick;
                    m1_gnt_nxt    = pick;
                    bus_op_nxt    = pick ? m1_op : m0_op;
                    bus_addr_nxt  = pick ? m1_addr : m0_addr;
                    if (bus_op_nxt)
                        bus_wr_data_nxt = pick ? m1_wr_data : m0_wr_data;
                end
            end
            ISSUE: begin
                if (bus_op) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WAIT_RD;
                    cnt_nxt   = LAT;
                end
            end
            WAIT_RD: begin
                if (cnt <= 4'd1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    if (sel) begin
                        m1_rd_data_nxt  = bus_rd_data;
                        m1_rd_valid_nxt = 1'b1;
                    end else begin
                        m0_rd_data_nxt  = bus_rd_data;
                        m0_rd_valid_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= 1'b1;
            sel         <= 1'b0;
            cnt         <= '0;
            m0_gnt      <= 1'b0;
            m1_gnt      <= 1'b0;
            m0_rd_valid <= 1'b0;
            m1_rd_valid <= 1'b0;
            m0_rd_data  <= '0;
            m1_rd_data  <= '0;
            bus_valid   <= 1'b0;
            bus_op      <= 1'b0;
            bus_addr    <= '0;
            bus_wr_data <= '0;
        end else begin
            state       <= state_nxt;
            last        <= last_nxt;
            sel         <= sel_nxt;
            cnt         <= cnt_nxt;
            m0_gnt      <= m0_gnt_nxt;
            m1_gnt      <= m1_gnt_nxt;
            m0_rd_valid <= m0_rd_valid_nxt;
            m1_rd_valid <= m1_rd_valid_nxt;
            m0_rd_data  <= m0_rd_data_nxt;
            m1_rd_data  <= m1_rd_data_nxt;
            bus_valid   <= bus_valid_nxt;
            bus_op      <= bus_op_nxt;
            bus_addr    <= bus_addr_nxt;
            bus_wr_data <= bus_wr_data_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// Directed bench for simple_bus_arbiter: one instance at RD_LATENCY=1, one at 3.
module tb_simple_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m1_req, m0_op, m1_op;
    logic [15:0] m0_addr, m1_addr, m0_wr_data, m1_wr_data, bus_rd_data;
    logic        m0_req3, m1_req3;

    logic        m0_gnt, m1_gnt, m0_rd_valid, m1_rd_valid;
    logic [15:0] m0_rd_data, m1_rd_data;
    logic        bus_valid, bus_op, busy;
    logic [15:0] bus_addr, bus_wr_data;

    logic        m0_gnt3, m1_gnt3, m0_rd_valid3, m1_rd_valid3;
    logic [15:0] m0_rd_data3, m1_rd_data3;
    logic        bus_valid3, bus_op3, busy3;
    logic [15:0] bus_addr3, bus_wr_data3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    simple_bus_arbiter dut1 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_op(m0_op), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
        .m1_req(m1_req), .m1_op(m1_op), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rd_valid(m0_rd_valid), .m1_rd_valid(m1_rd_valid),
        .m0_rd_data(m0_rd_data), .m1_rd_data(m1_rd_data),
        .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .busy(busy)
    );

    simple_bus_arbiter #(.RD_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req3), .m0_op(m0_op), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
        .m1_req(m1_req3), .m1_op(m1_op), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
        .m0_gnt(m0_gnt3), .m1_gnt(m1_gnt3),
        .m0_rd_valid(m0_rd_valid3), .m1_rd_valid(m1_rd_valid3),
        .m0_rd_data(m0_rd_data3), .m1_rd_data(m1_rd_data3),
        .bus_valid(bus_valid3), .bus_op(bus_op3), .bus_addr(bus_addr3),
        .bus_wr_data(bus_wr_data3), .bus_rd_data(bus_rd_data), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        m0_req = 0; m1_req = 0; m0_op = 0; m1_op = 0;
        m0_addr = '0; m1_addr = '0; m0_wr_data = '0; m1_wr_data = '0;
        bus_rd_data = '0; m0_req3 = 0; m1_req3 = 0;

        #2;
        chk("rst_bus_valid", 16'(bus_valid), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_m0_gnt", 16'(m0_gnt), 16'd0);
        chk("rst_m1_rd_data", m1_rd_data, 16'h0000);
        chk("rst_busy3", 16'(busy3), 16'd0);
        step(); step();
        rst_n = 1'b1;

        // m0 write alone
        m0_req = 1; m0_op = 1; m0_addr = 16'h0010; m0_wr_data = 16'hA5A5;
        step();
        chk("wr_bus_valid", 16'(bus_valid), 16'd1);
        chk("wr_bus_op", 16'(bus_op), 16'd1);
        chk("wr_bus_addr", bus_addr, 16'h0010);
        chk("wr_bus_wr_data", bus_wr_data, 16'hA5A5);
        chk("wr_m0_gnt", 16'(m0_gnt), 16'd1);
        chk("wr_m1_gnt", 16'(m1_gnt), 16'd0);
        chk("wr_busy", 16'(busy), 16'd1);
        m0_req = 0;
        step();
        chk("wr_after_valid", 16'(bus_valid), 16'd0);
        chk("wr_after_addr", bus_addr, 16'h0000);
        chk("wr_after_data", bus_wr_data, 16'h0000);
        chk("wr_after_gnt", 16'(m0_gnt), 16'd0);
        chk("wr_after_busy", 16'(busy), 16'd0);

        // m1 read, data returned one cycle after bus_valid
        m1_req = 1; m1_op = 0; m1_addr = 16'h0020; m1_wr_data = 16'hFFFF;
        step();
        chk("rd_bus_valid", 16'(bus_valid), 16'd1);
        chk("rd_bus_op", 16'(bus_op), 16'd0);
        chk("rd_bus_addr", bus_addr, 16'h0020);
        chk("rd_bus_wr_data", bus_wr_data, 16'h0000);
        chk("rd_m1_gnt", 16'(m1_gnt), 16'd1);
        m1_req = 0; bus_rd_data = 16'h1234;
        step();
        chk("rd_wait_busy", 16'(busy), 16'd1);
        chk("rd_wait_valid", 16'(m1_rd_valid), 16'd0);
        step();
        bus_rd_data = 16'h0000;
        chk("rd_m1_rd_valid", 16'(m1_rd_valid), 16'd1);
        chk("rd_m1_rd_data", m1_rd_data, 16'h1234);
        chk("rd_m0_rd_valid", 16'(m0_rd_valid), 16'd0);
        chk("rd_done_busy", 16'(busy), 16'd0);
        step();
        chk("rd_valid_pulse", 16'(m1_rd_valid), 16'd0);
        chk("rd_data_hold", m1_rd_data, 16'h1234);

        // asynchronous reset in the middle of an ISSUE cycle
        m0_req = 1; m0_op = 1; m0_addr = 16'h0011; m0_wr_data = 16'h7777;
        step();
        chk("pre_rst_valid", 16'(bus_valid), 16'd1);
        m0_req = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_bus_valid", 16'(bus_valid), 16'd0);
        chk("async_bus_op", 16'(bus_op), 16'd0);
        chk("async_bus_addr", bus_addr, 16'h0000);
        chk("async_bus_wr_data", bus_wr_data, 16'h0000);
        chk("async_m0_gnt", 16'(m0_gnt), 16'd0);
        chk("async_busy", 16'(busy), 16'd0);
        chk("async_m1_rd_data", m1_rd_data, 16'h0000);
        step();
        rst_n = 1'b1;

        // continuous conflict from reset: m0, m1, m0, m1 with idle gaps
        m0_req = 1; m0_op = 1; m0_addr = 16'h0100; m0_wr_data = 16'h1111;
        m1_req = 1; m1_op = 1; m1_addr = 16'h0200; m1_wr_data = 16'h2222;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("rr_valid_%0d", i), 16'(bus_valid), 16'(i % 2));
            chk($sformatf("rr_m0_gnt_%0d", i), 16'(m0_gnt), 16'(i == 1 || i == 5));
            chk($sformatf("rr_m1_gnt_%0d", i), 16'(m1_gnt), 16'(i == 3 || i == 7));
        end
        m0_req = 0; m1_req = 0;
        step();
        chk("rr_quiet", 16'(bus_valid), 16'd0);

        // m0 read completes with 5555, then a second m0 read is aborted by reset
        m0_req = 1; m0_op = 0; m0_addr = 16'h0040; bus_rd_data = 16'h5555;
        step();
        chk("m0rd_gnt", 16'(m0_gnt), 16'd1);
        m0_req = 0;
        step();
        step();
        chk("m0rd_valid", 16'(m0_rd_valid), 16'd1);
        chk("m0rd_data", m0_rd_data, 16'h5555);
        m0_req = 1; m0_addr = 16'h0044; bus_rd_data = 16'h6666;
        step();
        chk("abort_gnt", 16'(m0_gnt), 16'd1);
        m0_req = 0;
        step();
        chk("abort_in_wait", 16'(busy), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rd_data", m0_rd_data, 16'h0000);
        chk("abort_rd_valid", 16'(m0_rd_valid), 16'd0);
        chk("abort_busy", 16'(busy), 16'd0);
        step();
        rst_n = 1'b1;
        m0_req = 1; m0_op = 1; m1_req = 1; m1_op = 1;
        step();
        chk("post_abort_m0_gnt", 16'(m0_gnt), 16'd1);
        chk("post_abort_m1_gnt", 16'(m1_gnt), 16'd0);
        chk("post_abort_no_valid", 16'(m0_rd_valid), 16'd0);
        m0_req = 0; m1_req = 0;
        step();
        chk("post_abort_no_valid2", 16'(m0_rd_valid), 16'd0);
        chk("post_abort_rd_data", m0_rd_data, 16'h0000);
        step();

        // RD_LATENCY=3 instance: m0 read, data valid at T+4
        m0_req3 = 1; m0_op = 0; m0_addr = 16'h0030; bus_rd_data = 16'h0000;
        step();
        chk("lat3_bus_valid", 16'(bus_valid3), 16'd1);
        chk("lat3_busy_t1", 16'(busy3), 16'd1);
        m0_req3 = 0;
        step();
        chk("lat3_busy_t2", 16'(busy3), 16'd1);
        step();
        chk("lat3_busy_t3", 16'(busy3), 16'd1);
        chk("lat3_no_valid_t3", 16'(m0_rd_valid3), 16'd0);
        step();
        bus_rd_data = 16'hBEEF;
        chk("lat3_busy_t4", 16'(busy3), 16'd1);
        chk("lat3_no_valid_t4", 16'(m0_rd_valid3), 16'd0);
        step();
        bus_rd_data = 16'h0000;
        chk("lat3_rd_valid", 16'(m0_rd_valid3), 16'd1);
        chk("lat3_rd_data", m0_rd_data3, 16'hBEEF);
        chk("lat3_busy_t5", 16'(busy3), 16'd0);
        step();
        chk("lat3_valid_pulse", 16'(m0_rd_valid3), 16'd0);
        chk("lat3_data_hold", m0_rd_data3, 16'hBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simple_bus_arbiter.md
SIMPLE_BUS_ARBITER -- requirements
Module: simple_bus_arbiter

Interface
REQ-001 SHALL provide parameter RD_LATENCY, default 1, meaning cycles from the bus_valid cycle to the cycle bus_rd_data is valid; legal range 1..8.
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports m0_req / m1_req  input  1  requester wants a transaction; held high with fields stable until its gnt.
REQ-005 SHALL have ports m0_op / m1_op  input  1  1 = write, 0 = read.
REQ-006 SHALL have ports m0_addr / m1_addr  input  16  transaction address.
REQ-007 SHALL have ports m0_wr_data / m1_wr_data  input  16  write data; ignored for reads.
REQ-008 SHALL have ports m0_gnt / m1_gnt  output  1  one-cycle pulse: request issued on bus this cycle.
REQ-009 SHALL have ports m0_rd_valid / m1_rd_valid  output  1  one-cycle pulse: read data available.
REQ-010 SHALL have ports m0_rd_data / m1_rd_data  output  16  last read result for that requester.
REQ-011 SHALL have ports bus_valid  output  1, bus_op  output  1, bus_addr  output  16, bus_wr_data  output  16  shared bus command.
REQ-012 SHALL have port bus_rd_data  input  16  shared bus read return.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT_RD; all outputs registered.
REQ-015 IDLE: if any req high, SHALL select a winner, load bus fields, go to ISSUE next cycle; else stay IDLE.
REQ-016 Winner selection SHALL be round-robin: requester not granted last wins on conflict; single requester always wins.
REQ-017 Last-grant pointer SHALL reset to m1, so m0 wins the first conflict after reset.
REQ-018 ISSUE lasts exactly one cycle: bus_valid=1, bus_op/bus_addr from winner, winner gnt=1, other gnt=0.
REQ-019 ISSUE with read SHALL drive bus_wr_data=16'h0000; with write SHALL drive winner wr_data.
REQ-020 Outside ISSUE, bus_valid, bus_op, bus_addr, bus_wr_data SHALL all be 0.
REQ-021 ISSUE write -> IDLE; ISSUE read -> WAIT_RD.
REQ-022 WAIT_RD SHALL last RD_LATENCY cycles via down-counter; on its last cycle capture bus_rd_data into winner rd_data and go IDLE.
REQ-023 Winner rd_valid SHALL pulse one cycle, in the cycle after capture; rd_data holds until that requester's next read completes.
REQ-024 Requests SHALL be sampled only in IDLE; req changes during ISSUE/WAIT_RD have no effect.
REQ-025 Latency (req high in IDLE cycle T): gnt/bus_valid at T+1; read capture at T+1+RD_LATENCY; rd_valid at T+2+RD_LATENCY.
REQ-026 At least one idle bus cycle SHALL separate consecutive bus_valid pulses; max write rate one per 2 cycles.
REQ-027 A requester still holding req in the cycle after its gnt SHALL be treated as a new request.
REQ-028 rd_valid of a completed read and a new IDLE selection MAY coincide in the same cycle.

Reset
REQ-029 On rst_n low, SHALL immediately force: state IDLE, pointer m1, all gnt/rd_valid/bus_* outputs 0, rd_data 16'h0000, busy 0, counter 0.
REQ-030 Reset during ISSUE or WAIT_RD SHALL abort the transaction; no rd_valid SHALL follow; requester re-requests.
REQ-031 First arbitration SHALL occur in the first IDLE cycle after rst_n deasserts.

Verification
REQ-032 Reset: assert rst_n mid-sim -> all outputs 0 same timestep, busy=0.
REQ-033 m0 write addr 16'h0010 data 16'hA5A5 alone -> next cycle bus_valid=1, bus_op=1, bus_addr=16'h0010, bus_wr_data=16'hA5A5, m0_gnt=1; all 0 following cycle.
REQ-034 m1 read addr 16'h0020, bus_rd_data=16'h1234 one cycle after bus_valid -> bus_wr_data=0 during ISSUE; m1_rd_valid=1, m1_rd_data=16'h1234 at T+3.
REQ-035 m0 and m1 requesting continuously from reset -> grant order m0, m1, m0, m1; no bus_valid back-to-back.
REQ-036 Reset during WAIT_RD of m0 read -> no m0_rd_valid afterwards, m0_rd_data=0, next conflict granted to m0.
REQ-037 RD_LATENCY=3, m0 read, bus_rd_data=16'hBEEF at T+4 -> m0_rd_valid with 16'hBEEF at T+5; busy high T+1..T+4.
